// File: rtl/iref_seq.sv
`timescale 1ns/1ps
// iref_seq -- power-up / calibration sequencer for the current-reference macro.
//
// Turns a level enable request into an ordered drive of the reference cell:
// power-up, settle, calibrate, ready. Watches RDY_IREF with a calibration
// timeout and a bounded number of power-cycled retries. Reports READY or a
// sticky FAIL upward.
//
// Ports
//   CLK        system clock, all logic on posedge
//   RSTN       asynchronous active-low reset
//   EN         request reference on (level); EN=0 always returns to OFF
//   RDY_IREF   ready from reference cell (same clock domain)
//   PU_IREF    power-up to reference cell
//   CAL_IREF   calibrate strobe (level) to reference cell
//   READY      reference powered and calibrated
//   FAIL       sticky calibration failure (cleared only by EN=0)
//   STATE      current FSM state code (debug)
//   RETRY_CNT  retries consumed in the current enable session
module iref_seq #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned CAL_TIMEOUT = 1024,
  parameter int unsigned PD_CYC      = 4,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned CNT_W       = 12
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       RDY_IREF,
  output logic       PU_IREF,
  output logic       CAL_IREF,
  output logic       READY,
  output logic       FAIL,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_CAL   = 3'd2,
    S_READY = 3'd3,
    S_PDOWN = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_CYC - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [1:0]       retry;
  logic [1:0]       nxt_retry;
  logic             attempt_lost;

  // Next-state logic. A calibration timeout and a loss of reference while
  // READY share one retry/fail decision, resolved after the state case.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_retry    = retry;
    attempt_lost = 1'b0;

    case (state)
      S_OFF: begin
        nxt_state = S_PWRUP;
        nxt_cnt   = '0;
      end
      S_PWRUP: begin
        if (cnt == SETTLE_LAST) begin
          nxt_state = S_CAL;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      S_CAL: begin
        // RDY_IREF on the timeout cycle still counts as success.
        if (RDY_IREF) begin
          nxt_state = S_READY;
          nxt_cnt   = '0;
        end else if (cnt == CAL_LAST) begin
          attempt_lost = 1'b1;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      S_READY: begin
        if (!RDY_IREF) begin
          attempt_lost = 1'b1;
        end
      end
      S_PDOWN: begin
        if (cnt == PD_LAST) begin
          nxt_state = S_PWRUP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      S_FAIL: begin
        nxt_state = S_FAIL;
      end
      default: begin
        // Unreachable encodings recover to OFF.
        nxt_state = S_OFF;
        nxt_cnt   = '0;
        nxt_retry = '0;
      end
    endcase

    if (attempt_lost) begin
      nxt_cnt = '0;
      if (retry < RETRY_MAX) begin
        nxt_state = S_PDOWN;
        nxt_retry = retry + 2'd1;
      end else begin
        nxt_state = S_FAIL;
      end
    end

    // Dropping the enable overrides every other transition.
    if (!EN) begin
      nxt_state = S_OFF;
      nxt_cnt   = '0;
      nxt_retry = '0;
    end
  end

  // State, counter, retry count and registered outputs. Outputs are decoded
  // from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_OFF;
      cnt      <= '0;
      retry    <= '0;
      PU_IREF  <= 1'b0;
      CAL_IREF <= 1'b0;
      READY    <= 1'b0;
      FAIL     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      retry    <= nxt_retry;
      PU_IREF  <= (nxt_state == S_PWRUP) || (nxt_state == S_CAL) ||
                  (nxt_state == S_READY);
      CAL_IREF <= (nxt_state == S_CAL);
      READY    <= (nxt_state == S_READY);
      FAIL     <= (nxt_state == S_FAIL);
    end
  end

  assign STATE     = state;
  assign RETRY_CNT = retry;

endmodule

// File: tb/tb_iref_seq.sv
`timescale 1ns/1ps
// Bench for iref_seq. Each enable session is described by a list of
// calibration attempts (response delay or no response, optional loss of
// reference after READY) and expanded by plain phase arithmetic into a
// per-cycle table of expected state, retry count and input values, which is
// then played against the DUT.
module tb_iref_seq;

  localparam int SETTLE = 16;
  localparam int CALTO  = 1024;
  localparam int PDC    = 4;
  localparam int MAXR   = 2;

  localparam int S_OFF   = 0;
  localparam int S_PWRUP = 1;
  localparam int S_CAL   = 2;
  localparam int S_READY = 3;
  localparam int S_PDOWN = 4;
  localparam int S_FAIL  = 5;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       EN;
  logic       RDY_IREF;
  logic       PU_IREF;
  logic       CAL_IREF;
  logic       READY;
  logic       FAIL;
  logic [2:0] STATE;
  logic [1:0] RETRY_CNT;

  iref_seq #(
    .SETTLE_CYC (SETTLE),
    .CAL_TIMEOUT(CALTO),
    .PD_CYC     (PDC),
    .MAX_RETRY  (MAXR),
    .CNT_W      (12)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .EN       (EN),
    .RDY_IREF (RDY_IREF),
    .PU_IREF  (PU_IREF),
    .CAL_IREF (CAL_IREF),
    .READY    (READY),
    .FAIL     (FAIL),
    .STATE    (STATE),
    .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int b2i(input logic b);
    return (b === 1'b1) ? 1 : 0;
  endfunction

  // Expected per-cycle table: entry i holds the inputs applied before
  // posedge i and the state expected just after it.
  int q_st[$];
  int q_rt[$];
  int q_en[$];
  int q_rdy[$];

  // Session description: att_resp[a] < 0 means no response in attempt a,
  // otherwise RDY is sampled high after att_resp[a]+1 cycles of CAL.
  int att_resp[4];
  int att_loss[4];

  function automatic void push(input int st, input int n, input int rt,
                               input int en, input int rdy);
    for (int i = 0; i < n; i++) begin
      q_st.push_back(st);
      q_rt.push_back(rt);
      q_en.push_back(en);
      q_rdy.push_back(rdy < 0 ? int'($urandom_range(0, 1)) : rdy);
    end
  endfunction

  function automatic void build(input int n_att, input int hold,
                                input int abort_mode, input int abort_k);
    int retry;
    int a;
    int done;
    int rdy_edge;
    int r;
    int lost;
    int k;
    retry = 0; a = 0; done = 0; rdy_edge = -1;
    q_st.delete(); q_rt.delete(); q_en.delete(); q_rdy.delete();
    while (done == 0) begin
      lost = 0;
      push(S_PWRUP, SETTLE, retry, 1, -1);
      r = (a < n_att) ? att_resp[a] : -1;
      // First CAL cycle is entered from PWRUP, so RDY there is ignored.
      push(S_CAL, 1, retry, 1, -1);
      if (r >= 0) begin
        push(S_CAL, r, retry, 1, 0);
        if (rdy_edge < 0) rdy_edge = q_st.size();
        push(S_READY, hold, retry, 1, 1);
        if (a < n_att && att_loss[a] != 0) lost = 1;
        else done = 1;
      end else begin
        push(S_CAL, CALTO - 1, retry, 1, 0);
        lost = 1;
      end
      if (lost != 0) begin
        if (retry < MAXR) begin
          retry++;
          push(S_PDOWN, 1, retry, 1, 0);
          push(S_PDOWN, PDC - 1, retry, 1, -1);
          a++;
        end else begin
          push(S_FAIL, 1, retry, 1, 0);
          push(S_FAIL, hold, retry, 1, -1);
          done = 1;
        end
      end
    end
    if (abort_mode == 2 && rdy_edge < 0) abort_mode = 0;
    k = q_st.size();
    if (abort_mode == 1) k = (abort_k < 0) ? int'($urandom_range(0, q_st.size() - 1)) : abort_k;
    if (abort_mode == 2) k = rdy_edge;
    while (q_st.size() > k) begin
      void'(q_st.pop_back());
      void'(q_rt.pop_back());
      void'(q_en.pop_back());
      void'(q_rdy.pop_back());
    end
    push(S_OFF, 1, 0, 0, (abort_mode == 2) ? 1 : -1);
    push(S_OFF, 3, 0, 0, -1);
  endfunction

  task automatic check_outputs(input string name, input int i, input int st, input int rt);
    check($sformatf("%s[%0d] STATE", name, i), int'(STATE), st);
    check($sformatf("%s[%0d] PU", name, i), b2i(PU_IREF),
          (st == S_PWRUP || st == S_CAL || st == S_READY) ? 1 : 0);
    check($sformatf("%s[%0d] CAL", name, i), b2i(CAL_IREF), (st == S_CAL) ? 1 : 0);
    check($sformatf("%s[%0d] READY", name, i), b2i(READY), (st == S_READY) ? 1 : 0);
    check($sformatf("%s[%0d] FAILOUT", name, i), b2i(FAIL), (st == S_FAIL) ? 1 : 0);
    check($sformatf("%s[%0d] RETRY", name, i), int'(RETRY_CNT), rt);
  endtask

  task automatic play(input string name, input int limit);
    for (int i = 0; i < q_st.size() && i < limit; i++) begin
      EN       = (q_en[i] != 0);
      RDY_IREF = (q_rdy[i] != 0);
      @(posedge CLK);
      #1;
      check_outputs(name, i, q_st[i], q_rt[i]);
    end
  endtask

  task automatic run(input string name, input int n_att, input int hold,
                     input int abort_mode, input int abort_k);
    build(n_att, hold, abort_mode, abort_k);
    play(name, q_st.size());
  endtask

  task automatic set_att(input int r0, input int r1, input int r2, input int r3,
                         input int l0, input int l1, input int l2, input int l3);
    att_resp[0] = r0; att_resp[1] = r1; att_resp[2] = r2; att_resp[3] = r3;
    att_loss[0] = l0; att_loss[1] = l1; att_loss[2] = l2; att_loss[3] = l3;
  endtask

  initial begin
    RSTN = 1'b0;
    EN = 1'b0;
    RDY_IREF = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset", 0, S_OFF, 0);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    check_outputs("idle", 0, S_OFF, 0);

    // Nominal: RDY sampled high after 900 cycles of CAL.
    set_att(899, 0, 0, 0, 0, 0, 0, 0);
    run("nominal", 1, 20, 0, 0);
    // First CAL ignored, second answered.
    set_att(-1, 99, 0, 0, 0, 0, 0, 0);
    run("retry1", 2, 20, 0, 0);
    // Never answered: three windows then FAIL, then EN drop.
    set_att(-1, -1, -1, -1, 0, 0, 0, 0);
    run("hardfail", 3, 10, 0, 0);
    // RDY on the timeout cycle is success.
    set_att(CALTO - 1, 0, 0, 0, 0, 0, 0, 0);
    run("to_edge_ok", 1, 10, 0, 0);
    // Loss of reference in READY, repeated until FAIL.
    set_att(50, 60, 70, 0, 1, 1, 1, 0);
    run("loss", 3, 30, 0, 0);
    // Aborts: mid-PWRUP, mid-CAL, on the RDY edge, on the timeout edge.
    set_att(100, 0, 0, 0, 0, 0, 0, 0);
    run("abort_pwrup", 1, 10, 1, 8);
    set_att(-1, 0, 0, 0, 0, 0, 0, 0);
    run("abort_cal", 1, 10, 1, SETTLE + 500);
    set_att(300, 0, 0, 0, 0, 0, 0, 0);
    run("abort_rdy", 1, 10, 2, 0);
    set_att(-1, 50, 0, 0, 0, 0, 0, 0);
    run("abort_to", 2, 10, 1, SETTLE + CALTO);
    // Loss after a retry, recovery on the last allowed attempt.
    set_att(-1, 40, 30, 0, 0, 1, 0, 0);
    run("loss_recover", 3, 15, 0, 0);

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      int n;
      int sel;
      n = int'($urandom_range(1, 4));
      for (int a = 0; a < 4; a++) begin
        sel = int'($urandom_range(0, 9));
        att_resp[a] = (sel < 2) ? -1 : (sel == 2) ? CALTO - 1 : int'($urandom_range(0, 300));
        att_loss[a] = ($urandom_range(0, 2) == 0) ? 1 : 0;
      end
      run($sformatf("rand%0d", s), n, int'($urandom_range(1, 40)),
          int'($urandom_range(0, 2)), -1);
    end

    // Asynchronous reset mid-CAL of the second attempt (RETRY_CNT=1).
    set_att(-1, 500, 0, 0, 0, 0, 0, 0);
    build(2, 10, 0, 0);
    play("areset", SETTLE + CALTO + PDC + SETTLE + 100);
    check_outputs("areset_pre", 0, S_CAL, 1);
    #3;
    RSTN = 1'b0;
    #1;
    check_outputs("areset_now", 0, S_OFF, 0);
    EN = 1'b0;
    RDY_IREF = 1'b0;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_outputs("areset_post", 0, S_OFF, 0);
    end
    // Session after reset restarts cleanly.
    set_att(10, 0, 0, 0, 0, 0, 0, 0);
    run("after_reset", 1, 5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
